mc_datapath_mul: RTL and testbench
==================================

Name: mc_datapath_mul

Overview:
Parametrised multicycle ARM-subset datapath: PC, instruction, data, operand and ALU-out registers, register file, extender, ALU and result muxing. Adds an iterative shift-add multiplier sequenced by a start/busy/done handshake with the external controller. Sits between memory (Adr/WriteData/ReadData) and the multicycle controller, which drives every select and enable.

Parameters:
WIDTH, 32, data/address width; legal values 32 or 64; instructions stay 32 bits.
MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all datapath registers and the multiplier
Adr  out  WIDTH  memory address: PC when AdrSrc=0, Result when AdrSrc=1
WriteData  out  WIDTH  registered RD2, store data
ReadData  in  WIDTH  memory read data
Instr  out  32  instruction register
ALUFlags  out  4  combinational NZCV from the ALU
PCWrite/RegWrite/IRWrite/AdrSrc  in  1 each  controller enables/selects
RegSrc  in  2  [0]: RA1=15 else Instr[19:16]; [1]: RA2=Instr[15:12] else Instr[3:0]
ALUSrcA  in  2  00 A, 01 PC, 1x zero
ALUSrcB  in  2  00 WriteData, 01 ExtImm, 10 constant 4, 11 zero
ResultSrc  in  2  00 ALUOut, 01 Data, 10 ALUResult, 11 MulOut
ImmSrc  in  2  00 zext Instr[7:0], 01 zext Instr[11:0], 10 sext(Instr[23:0])<<2, 11 zero
ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, others ADD
MulStart  in  1  begin multiply of SrcA x SrcB
MulBusy  out  1  multiplier iterating
MulDone  out  1  one-cycle pulse, MulOut valid

Behaviour:
- Reset: PC, Instr, Data, A, WriteData, ALUOut, MulOut, multiplier state = 0; MulBusy=0, MulDone=0. Register-file contents not reset.
- PC loads Result when PCWrite; Instr loads ReadData when IRWrite; Data, A (RD1), WriteData (RD2) and ALUOut (ALUResult) load every cycle.
- Register file: 16 x WIDTH, two combinational reads, one synchronous write at Instr[15:12] of Result when RegWrite. A read of address 15 returns the current Result bus; writes to 15 are dropped (PC owns R15).
- ALU: WIDTH-bit. N = result MSB; Z = result==0. C = carry-out for ADD, NOT borrow for SUB, 0 for logic ops. V = signed overflow for ADD/SUB, 0 for logic ops.
- Multiplier states IDLE, RUN.
- IDLE + MulStart: capture multiplicand=SrcA, multiplier=SrcB; clear accumulator; count=WIDTH/MUL_BITS; go to RUN; MulBusy=1 from the next cycle.
- RUN, each edge: accumulator += multiplicand x (low MUL_BITS of multiplier); multiplicand <<= MUL_BITS; multiplier >>= MUL_BITS; count--.
- On the edge where count reaches 0: MulOut <= accumulator, low WIDTH bits only (mod 2^WIDTH, wrap-around, no flags); go to IDLE.
- MulDone is high in the cycle after that edge; MulBusy falls in the same cycle.
- Latency: MulDone high exactly WIDTH/MUL_BITS cycles after the MulStart edge.
- MulStart while MulBusy=1: ignored, operands untouched. MulStart in the MulDone cycle: accepted; new run begins.
- MulOut holds its value until the next completion or reset. Reset mid-RUN: aborts to IDLE; MulOut=0; no MulDone.
- Multiplier operation never stalls or gates other datapath registers; the controller must hold Result consumers until MulDone.

Optional Feature:
DATAPATH_MUL_EARLY_EN
- Defined: RUN also terminates on the edge where the shifted multiplier becomes 0, so latency = max(1, ceil(msb_index(SrcB)+1 / MUL_BITS)) cycles. A zero multiplier completes in 1 cycle with MulOut=0.
- Undefined: fixed latency WIDTH/MUL_BITS regardless of operands.
- Results are identical either way.

Test Plan:
- Assert reset mid-cycle with PC=0x20 -> PC, Instr, ALUOut, MulOut = 0 immediately; MulBusy=0.
- Fetch: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1, IRWrite=1, ReadData=0xE2801005 -> next edge PC=4, Instr=0xE2801005, Adr=4.
- ALU: SrcA=0x7FFFFFFF, SrcB=1, ADD -> result 0x80000000, flags N=1, Z=0, C=0, V=1. SUB with 5-5 -> Z=1, C=1.
- Multiply 7 x 6, WIDTH=32 -> MulDone exactly 32 cycles after start (MUL_BITS=1), 8 cycles after start (MUL_BITS=4); MulOut=42; ResultSrc=11 drives 42.
- 0xFFFFFFFF x 2 -> MulOut=0xFFFFFFFE. MulStart re-pulsed at cycle 5 of a run -> ignored, same latency and result.
- Reset at cycle 10 of a run -> MulBusy=0, MulOut=0, no MulDone. With DATAPATH_MUL_EARLY_EN, 5 x 3 at MUL_BITS=1 -> MulDone 2 cycles after start, MulOut=15.

Source files
------------

// File: rtl/mc_datapath_mul.sv
// rtl/mc_datapath_mul.sv - multicycle ARM-subset datapath with iterative shift-add multiplier
// Optional early termination on an exhausted multiplier: DATAPATH_MUL_EARLY_EN
module mc_datapath_mul #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [2:0]       ALUControl,
    input  logic             MulStart,
    output logic             MulBusy,
    output logic             MulDone
);

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic {M_IDLE, M_RUN} mul_state_t;

    logic [WIDTH-1:0] pc, data, a_reg, wd_reg, aluout, mulout;
    logic [31:0]      instr_r;
    logic [WIDTH-1:0] rf [0:15];
    logic [3:0]       ra1, ra2, wa;
    logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, alu_result, result;
    logic [WIDTH:0]   sum;
    logic             flag_c, flag_v;

    mul_state_t       mstate;
    logic [WIDTH-1:0] mcand, mplier, acc, partial, acc_next, mplier_next;
    logic [CW-1:0]    count, count_next;
    logic             last;

    assign Instr     = instr_r;
    assign WriteData = wd_reg;
    assign Adr       = AdrSrc ? result : pc;

    assign ra1 = RegSrc[0] ? 4'd15 : instr_r[19:16];
    assign ra2 = RegSrc[1] ? instr_r[15:12] : instr_r[3:0];
    assign wa  = instr_r[15:12];

    // R15 lives in the PC; reading it yields whatever is on the result bus
    assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
    assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];

    always_comb begin
        case (ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr_r[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr_r[11:0]};
            2'b10:   ext_imm = {{(WIDTH-26){instr_r[23]}}, instr_r[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    assign src_a = ALUSrcA[1] ? '0 : (ALUSrcA[0] ? pc : a_reg);

    always_comb begin
        case (ALUSrcB)
            2'b00:   src_b = wd_reg;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = WIDTH'(4);
            default: src_b = '0;
        endcase
    end

    always_comb begin
        sum        = '0;
        alu_result = '0;
        flag_c     = 1'b0;
        flag_v     = 1'b0;
        case (ALUControl)
            3'b001: begin
                // subtract as a + ~b + 1 so the carry-out is NOT borrow
                sum        = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
                alu_result = sum[WIDTH-1:0];
                flag_c     = sum[WIDTH];
                flag_v     = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            default: begin
                sum        = {1'b0, src_a} + {1'b0, src_b};
                alu_result = sum[WIDTH-1:0];
                flag_c     = sum[WIDTH];
                flag_v     = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
        endcase
    end

    assign ALUFlags = {alu_result[WIDTH-1], (alu_result == '0), flag_c, flag_v};

    always_comb begin
        case (ResultSrc)
            2'b00:   result = aluout;
            2'b01:   result = data;
            2'b10:   result = alu_result;
            default: result = mulout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RegWrite && (wa != 4'd15))
            rf[wa] <= result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            instr_r <= '0;
            data    <= '0;
            a_reg   <= '0;
            wd_reg  <= '0;
            aluout  <= '0;
        end else begin
            if (PCWrite) pc <= result;
            if (IRWrite) instr_r <= ReadData[31:0];
            data   <= ReadData;
            a_reg  <= rd1;
            wd_reg <= rd2;
            aluout <= alu_result;
        end
    end

    // one radix-2^MUL_BITS digit of the multiplier per cycle
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (mplier[i]) partial = partial + (mcand << i);
        acc_next    = acc + partial;
        mplier_next = mplier >> MUL_BITS;
        count_next  = count - CW'(1);
`ifdef DATAPATH_MUL_EARLY_EN
        last = (count_next == '0) || (mplier_next == '0);
`else
        last = (count_next == '0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate  <= M_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            mulout  <= '0;
            MulBusy <= 1'b0;
            MulDone <= 1'b0;
        end else begin
            MulDone <= 1'b0;
            case (mstate)
                M_IDLE: begin
                    if (MulStart) begin
                        mcand   <= src_a;
                        mplier  <= src_b;
                        acc     <= '0;
                        count   <= CW'(STEPS);
                        MulBusy <= 1'b1;
                        mstate  <= M_RUN;
                    end
                end
                default: begin
                    acc    <= acc_next;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier_next;
                    count  <= count_next;
                    if (last) begin
                        mulout  <= acc_next;
                        MulDone <= 1'b1;
                        MulBusy <= 1'b0;
                        mstate  <= M_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath_mul.sv
// tb/tb_mc_datapath_mul.sv - scoreboard bench for mc_datapath_mul
module tb_mc_datapath_mul;

    localparam int W  = 32;
    localparam int MB = 1;
    localparam int N  = W / MB;
`ifdef DATAPATH_MUL_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] Adr, WriteData, ReadData;
    logic [31:0]  Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]   ALUControl;
    logic         MulStart, MulBusy, MulDone;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    mc_datapath_mul #(.WIDTH(W), .MUL_BITS(MB)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        int msb = -1;
        for (int i = 0; i < W; i++)
            if (b[i]) msb = i;
        if (!EARLY) return N;
        if (msb < 0) return 1;
        return (msb + MB) / MB;
    endfunction

    // monitor: the bench holds AdrSrc=1/ResultSrc=11 during multiplies, so Adr shows MulOut
    always @(negedge clk) begin
        if (!reset && MulDone) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mul_unexpected_done: got MulDone=1 at cycle %0d expected 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("mul_result", Adr, mon_e.val);
                check("mul_latency", W'(cyc), W'(mon_e.due));
                check("mul_busy_at_done", W'(MulBusy), '0);
            end
        end
    end

    task automatic write_reg(input logic [3:0] r, input logic [W-1:0] v);
        ReadData = W'({16'h0, r, 12'h0});
        IRWrite  = 1'b1;
        step();
        IRWrite  = 1'b0;
        ReadData = v;
        step();
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        step();
        RegWrite  = 1'b0;
    endtask

    task automatic load_instr(input logic [31:0] v);
        ReadData = W'(v);
        IRWrite  = 1'b1;
        step();
        IRWrite  = 1'b0;
        step();
    endtask

    task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        write_reg(4'd3, a);
        write_reg(4'd4, b);
        load_instr(32'h0003_0004);
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b11;
        AdrSrc    = 1'b1;
        MulStart  = 1'b1;
        e.val = a * b;
        e.due = cyc + 1 + exp_lat(b);
        if (push) sb.push_back(e);
        step();
        MulStart = 1'b0;
        check("mul_busy_after_start", W'(MulBusy), W'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL mul_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e2;
        bit   seen;
        reset = 1'b1;
        ReadData = '0;
        {PCWrite, RegWrite, IRWrite, AdrSrc, MulStart} = '0;
        {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} = '0;
        ALUControl = 3'b000;
        step();
        step();
        check("rst_pc", Adr, '0);
        check("rst_instr", W'(Instr), '0);
        check("rst_busy", W'(MulBusy), '0);
        check("rst_done", W'(MulDone), '0);
        reset = 1'b0;

        ReadData = W'(32'h20);
        IRWrite  = 1'b1;
        step();
        IRWrite   = 1'b0;
        ResultSrc = 2'b01;
        PCWrite   = 1'b1;
        step();
        PCWrite = 1'b0;
        check("pc_load", Adr, W'(32'h20));
        #3 reset = 1'b1;
        #1;
        check("async_rst_pc", Adr, '0);
        check("async_rst_instr", W'(Instr), '0);
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        #1 check("async_rst_aluout", Adr, '0);
        ResultSrc = 2'b11;
        #1 check("async_rst_mulout", Adr, '0);
        check("async_rst_busy", W'(MulBusy), '0);
        step();
        reset = 1'b0;

        AdrSrc = 1'b0; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUControl = 3'b000;
        ResultSrc = 2'b10; PCWrite = 1'b1; IRWrite = 1'b1; ReadData = W'(32'hE280_1005);
        step();
        PCWrite = 1'b0;
        IRWrite = 1'b0;
        check("fetch_pc", Adr, W'(32'h4));
        check("fetch_instr", W'(Instr), W'(32'hE280_1005));

        write_reg(4'd1, W'(32'h7FFF_FFFF));
        load_instr(32'h0001_0001);
        ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 3'b000;
        ResultSrc = 2'b10; AdrSrc = 1'b1;
        #1;
        check("add_ovf_result", Adr, W'(32'h8000_0000));
        check("add_ovf_flags", W'(ALUFlags), W'(4'b1001));
        ALUControl = 3'b010;
        #1;
        check("and_result", Adr, W'(32'h1));
        check("and_flags", W'(ALUFlags), W'(4'b0000));
        write_reg(4'd2, W'(32'h5));
        load_instr(32'h0002_0005);
        ALUControl = 3'b001; ResultSrc = 2'b10;
        #1;
        check("sub_zero_result", Adr, '0);
        check("sub_zero_flags", W'(ALUFlags), W'(4'b0110));

        ReadData = W'(32'hABCD);
        step();
        ResultSrc = 2'b01;
        RegSrc    = 2'b01;
        step();
        RegSrc = 2'b00; ResultSrc = 2'b10; ALUSrcA = 2'b00; ALUSrcB = 2'b11; ALUControl = 3'b000;
        #1 check("r15_reads_result", Adr, W'(32'hABCD));

        start_mul(W'(32'd7), W'(32'd6), 1'b1);
        wait_drain();
        start_mul(W'(32'hFFFF_FFFF), W'(32'd2), 1'b1);
        wait_drain();
        start_mul(W'(32'h0001_0000), W'(32'h0001_0000), 1'b1);
        wait_drain();
        start_mul(W'(32'd9), W'(32'd0), 1'b1);
        wait_drain();

        start_mul(W'(32'h1234), W'(32'h10), 1'b1);
        repeat (2) step();
        ALUSrcB  = 2'b01;
        ImmSrc   = 2'b11;
        MulStart = 1'b1;
        step();
        MulStart = 1'b0;
        ALUSrcB  = 2'b00;
        wait_drain();

        start_mul(W'(32'd7), W'(32'd6), 1'b1);
        for (int i = 0; i < 400 && !MulDone; i++) step();
        MulStart = 1'b1;
        e2.val = W'(32'd42);
        e2.due = cyc + 1 + exp_lat(W'(32'd6));
        sb.push_back(e2);
        step();
        MulStart = 1'b0;
        wait_drain();

        start_mul(W'(32'h55), W'(32'h8000_0001), 1'b0);
        repeat (8) step();
        #3 reset = 1'b1;
        #1;
        check("mid_rst_busy", W'(MulBusy), '0);
        check("mid_rst_mulout", Adr, '0);
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MulDone) seen = 1'b1;
        end
        check("mid_rst_no_done", W'(seen), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
